// File: rtl/alu_iter.sv
// alu_iter: single-cycle logic/arith ALU with an iterative radix-2 unsigned multiply.
// Latency: 1 edge for AND/OR/ADD/SUB/SLT/NOR; MULTU results appear WIDTH+1 cycles after accept.
// Backpressure: ready_o=0 while a multiply runs; start_i is dropped (not queued) when not ready.
// Ports: clk_i/rst_n clock and async active-low reset; start_i/op_i/src1_i/src2_i request;
//        ready_o/busy_o status; valid_o one-cycle result strobe; result_o/hi_o/zero_o/overflow_o
//        registered results held between strobes.
module alu_iter #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand;
  // Low half starts as the multiplier and is shifted out LSB-first while the
  // partial product grows into the upper half.
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       add_hi;

  logic                 accept;
  logic                 is_mul;
  logic                 mul_done;

  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     diff;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic                 slt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;

  assign ready_o  = (state == IDLE);
  assign busy_o   = ~ready_o;
  assign accept   = start_i && (state == IDLE);
  assign is_mul   = MUL_EN && (op_i == OP_MULTU);
  // One extra cycle after the last shift step is spent writing the result.
  assign mul_done = (state == MUL) && (cnt == CW'(WIDTH));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (mul_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ALU
  always_comb begin
    sum     = src1_i + src2_i;
    diff    = src1_i - src2_i;
    add_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
    sub_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
    // Sign of the difference is wrong exactly when the subtraction overflowed.
    slt     = diff[WIDTH-1] ^ sub_ovf;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_i)
      OP_AND: alu_res = src1_i & src2_i;
      OP_OR:  alu_res = src1_i | src2_i;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR: alu_res = ~(src1_i | src2_i);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // keeping the carry so the right shift loses nothing.
  always_comb begin
    add_hi = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) add_hi = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      mcand      <= '0;
      prod       <= '0;
      valid_o    <= 1'b0;
      result_o   <= '0;
      hi_o       <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand <= src1_i;
          prod  <= {{WIDTH{1'b0}}, src2_i};
          cnt   <= '0;
        end else begin
          result_o   <= alu_res;
          hi_o       <= '0;
          zero_o     <= (alu_res == '0);
          overflow_o <= alu_ovf;
          valid_o    <= 1'b1;
        end
      end else if (state == MUL) begin
        if (mul_done) begin
          result_o   <= prod[WIDTH-1:0];
          hi_o       <= prod[2*WIDTH-1:WIDTH];
          zero_o     <= (prod[WIDTH-1:0] == '0);
          overflow_o <= 1'b0;
          valid_o    <= 1'b1;
          cnt        <= '0;
        end else begin
          prod <= {add_hi, prod[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed bench for alu_iter with a result scoreboard.
// Latency: expectations pushed on accept, popped on each valid_o strobe.
// Backpressure: exercises ignored starts while busy and back-to-back issue.
module tb_alu_iter;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_BAD   = 4'b1111;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        start0 = 1'b0;
  logic [3:0]  op_i = 4'b0000;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;

  logic        ready_o, busy_o, valid_o, zero_o, overflow_o;
  logic [31:0] result_o, hi_o;
  logic        ready0, busy0, valid0, zero0, ovf0;
  logic [31:0] result0, hi0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  alu_iter #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready_o), .busy_o(busy_o),
    .valid_o(valid_o), .result_o(result_o), .hi_o(hi_o), .zero_o(zero_o),
    .overflow_o(overflow_o)
  );

  alu_iter #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_nomul (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start0), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready0), .busy_o(busy0),
    .valid_o(valid0), .result_o(result0), .hi_o(hi0), .zero_o(zero0),
    .overflow_o(ovf0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model written from the arithmetic definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    e = '0;
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_NOR: e.res = ~(a | b);
      OP_ADD: begin
        s     = {a[31], a} + {b[31], b};
        e.res = s[31:0];
        e.ovf = (s[32] != s[31]);
      end
      OP_SUB: begin
        s     = {a[31], a} - {b[31], b};
        e.res = s[31:0];
        e.ovf = (s[32] != s[31]);
      end
      OP_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MULTU: begin
        p     = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    tick();
    start_i = 1'b0;
    sb_q.push_back(model(op, a, b));
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 64'(valid_o), 64'(1'b0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result",   64'(result_o),   64'(e.res));
        check("sb_hi",       64'(hi_o),       64'(e.hi));
        check("sb_zero",     64'(zero_o),     64'(e.zero));
        check("sb_overflow", 64'(overflow_o), 64'(e.ovf));
      end
    end
  end

  initial begin
    int k;
    int vcnt;

    // Reset state
    repeat (2) tick();
    check("rst_ready",  64'(ready_o),    64'(1'b1));
    check("rst_busy",   64'(busy_o),     64'(1'b0));
    check("rst_valid",  64'(valid_o),    64'(1'b0));
    check("rst_result", 64'(result_o),   64'(0));
    check("rst_hi",     64'(hi_o),       64'(0));
    check("rst_zero",   64'(zero_o),     64'(1'b1));
    check("rst_ovf",    64'(overflow_o), 64'(1'b0));
    rst_n = 1'b1;

    // First edge after reset release accepts the start
    issue(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    check("sub_valid",  64'(valid_o),    64'(1'b1));
    check("sub_result", 64'(result_o),   64'(32'h7FFF_FFFF));
    check("sub_ovf",    64'(overflow_o), 64'(1'b1));
    tick();
    check("sub_valid_pulse", 64'(valid_o), 64'(1'b0));

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(OP_SUB, 32'h0000_0005, 32'h0000_0005);
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(OP_OR,  32'hF000_0000, 32'h0000_000F);
    issue(OP_NOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    issue(OP_SLT, 32'h8000_0000, 32'h0000_0001);
    check("slt_result", 64'(result_o), 64'(1));
    issue(OP_SLT, 32'h0000_0001, 32'h8000_0000);
    check("slt_swap_result", 64'(result_o), 64'(0));
    check("slt_swap_zero",   64'(zero_o),   64'(1'b1));
    issue(OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);

    // Full-width multiply with latency and busy window
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_ready_low", 64'(ready_o), 64'(1'b0));
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c < 33) begin
        check("mul_busy",     64'(busy_o),  64'(1'b1));
        check("mul_no_valid", 64'(valid_o), 64'(1'b0));
      end else begin
        check("mul_valid_33", 64'(valid_o), 64'(1'b1));
        check("mul_ready_1",  64'(ready_o), 64'(1'b1));
        check("mul_hi",       64'(hi_o),    64'(32'hFFFF_FFFE));
        check("mul_lo",       64'(result_o), 64'(32'h0000_0001));
      end
    end

    // Start while busy is dropped; operands change mid-multiply
    issue(OP_MULTU, 32'd7, 32'd6);
    k = 0;
    while (!valid_o && k < 40) begin
      if (k == 4) begin
        start_i = 1'b1;
        op_i    = OP_ADD;
        src1_i  = 32'd1;
        src2_i  = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      tick();
      k++;
      if (k == 5) check("ignored_start_busy", 64'(ready_o), 64'(1'b0));
    end
    start_i = 1'b0;
    check("mul7x6_latency", 64'(k), 64'(33));
    check("mul7x6_lo", 64'(result_o), 64'(42));
    check("mul7x6_hi", 64'(hi_o),     64'(0));
    check("mul7x6_ready", 64'(ready_o), 64'(1'b1));
    issue(OP_ADD, 32'd1, 32'd1);
    check("b2b_add_valid",  64'(valid_o),  64'(1'b1));
    check("b2b_add_result", 64'(result_o), 64'(2));

    // Reset mid-multiply aborts with no strobe
    issue(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    void'(sb_q.pop_back());
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready",  64'(ready_o),    64'(1'b1));
    check("abort_busy",   64'(busy_o),     64'(1'b0));
    check("abort_valid",  64'(valid_o),    64'(1'b0));
    check("abort_result", 64'(result_o),   64'(0));
    check("abort_hi",     64'(hi_o),       64'(0));
    check("abort_zero",   64'(zero_o),     64'(1'b1));
    check("abort_ovf",    64'(overflow_o), 64'(1'b0));
    tick();
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid_o) vcnt++;
    end
    check("abort_no_valid", 64'(vcnt), 64'(0));
    check("abort_idle", 64'(ready_o), 64'(1'b1));
    issue(OP_ADD, 32'd3, 32'd4);
    check("post_abort_add", 64'(result_o), 64'(7));
    repeat (3) tick();
    check("hold_valid",  64'(valid_o),  64'(1'b0));
    check("hold_result", 64'(result_o), 64'(7));

    // Undefined ops, including MULTU with the multiplier disabled
    issue(OP_BAD, 32'd5, 32'd0);
    check("undef_valid", 64'(valid_o), 64'(1'b1));
    check("undef_zero",  64'(zero_o),  64'(1'b1));
    tick();
    start0 = 1'b1;
    op_i   = OP_MULTU;
    src1_i = 32'd5;
    src2_i = 32'd3;
    tick();
    start0 = 1'b0;
    check("nomul_valid",  64'(valid0),  64'(1'b1));
    check("nomul_result", 64'(result0), 64'(0));
    check("nomul_hi",     64'(hi0),     64'(0));
    check("nomul_zero",   64'(zero0),   64'(1'b1));
    check("nomul_ovf",    64'(ovf0),    64'(1'b0));
    check("nomul_ready",  64'(ready0),  64'(1'b1));
    tick();
    check("nomul_pulse",  64'(valid0),  64'(1'b0));

    repeat (5) tick();
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 32: operand and result width in bits, legal range 4..64.
REQ-003 Parameter MUL_EN, default 1: 1 enables the multi-cycle unsigned multiply; 0 makes op 4'b1000 an undefined op.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  request; accepted only when ready_o=1.
REQ-007 op_i  input  4  operation code, sampled on accept.
REQ-008 src1_i, src2_i  input  WIDTH each  operands, sampled on accept.
REQ-009 ready_o  output  1  block idle; a start this cycle is accepted.
REQ-010 busy_o  output  1  multiply in progress; equals ~ready_o.
REQ-011 valid_o  output  1  one-cycle pulse when result outputs update.
REQ-012 result_o  output  WIDTH  result; low half of the product for multiply.
REQ-013 hi_o  output  WIDTH  high half of the product; 0 for other ops.
REQ-014 zero_o  output  1  result_o == 0, registered together with result_o.
REQ-015 overflow_o  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Function
REQ-016 Ops SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (src1-src2), 0111 SLT signed, 1100 NOR, 1000 MULTU.
REQ-017 Single-cycle ops: on accept at edge N, result_o/hi_o/zero_o/overflow_o SHALL be registered at edge N, with valid_o=1 for the cycle after edge N only.
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow_o=1 when the operand signs (after SUB inversion) match and the result sign differs.
REQ-019 SLT SHALL return 1 in bit 0 (upper bits 0) iff src1<src2 signed, correct even when src1-src2 overflows (sign XOR overflow).
REQ-020 Undefined op: result_o=0, hi_o=0, overflow_o=0, zero_o=1, valid_o pulsed as for a single-cycle op.
REQ-021 FSM states SHALL be IDLE and MUL; reset state is IDLE.
REQ-022 IDLE->MUL on accepted MULTU (MUL_EN=1); MUL->IDLE when the iteration counter reaches WIDTH; all other ops stay in IDLE.
REQ-023 MULTU SHALL be radix-2 shift-add using a $clog2(WIDTH+1)-bit counter, exactly one bit per cycle.
REQ-024 MULTU SHALL update outputs with valid_o=1 exactly WIDTH+1 cycles after the accept edge, producing the full 2*WIDTH-bit unsigned product {hi_o,result_o}.
REQ-025 ready_o SHALL be 0 from the accept edge of MULTU until the edge that writes its result; it SHALL be 1 in the valid_o cycle, so back-to-back starts are allowed.
REQ-026 start_i while busy SHALL be ignored, with no queueing and no state change.
REQ-027 Operands SHALL be captured on accept; input changes during MUL SHALL NOT affect the result.
REQ-028 Outputs SHALL hold their last values between valid_o pulses.
REQ-029 zero_o for MULTU SHALL reflect result_o only (low half).

Reset
REQ-030 While rst_n=0: state IDLE, counter 0, ready_o=1, busy_o=0, valid_o=0, result_o=0, hi_o=0, zero_o=1, overflow_o=0.
REQ-031 Reset asserted mid-multiply SHALL abort the operation immediately, with no valid_o pulse afterward.
REQ-032 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification (WIDTH=32, MUL_EN=1)
REQ-033 SUB 0x80000000-0x00000001 -> result_o=0x7FFFFFFF, overflow_o=1, zero_o=0, valid_o one cycle after accept.
REQ-034 SLT src1=0x80000000, src2=0x00000001 -> result_o=0x00000001; swapped operands -> 0x00000000, zero_o=1.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, result_o=0x00000001, valid_o exactly 33 cycles after accept, busy_o=1 in between.
REQ-036 MULTU 7x6 accepted, ADD 1+1 start asserted on cycle 5 -> ADD ignored, outputs 0/42; an ADD issued in the valid_o cycle returns 2 one cycle later.
REQ-037 rst_n pulsed low at cycle 10 of a MULTU -> outputs at reset values, no valid_o, ready_o=1; the next ADD 3+4 returns 7.
REQ-038 Op 4'b1111 with src1=5 -> result_o=0, zero_o=1, valid_o pulsed; repeat with MUL_EN=0 and op 1000 -> same response.
